// File: rtl/cordic_atan_seq_if.sv
// Streaming valid/ready bundle for the vectoring-mode CORDIC: vector in, angle and magnitude out.
// The slave modport is the CORDIC block; the master modport drives vectors and drains results.
interface cordic_atan_seq_if #(
  parameter int unsigned FRAC_BITS = 30
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [FRAC_BITS+1:0] x_in;
  logic signed [FRAC_BITS+1:0] y_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [FRAC_BITS+2:0] theta_out;
  logic        [FRAC_BITS+3:0] mag_out;

  modport master (
    output in_valid,
    output x_in,
    output y_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  theta_out,
    input  mag_out
  );

  modport slave (
    input  in_valid,
    input  x_in,
    input  y_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output theta_out,
    output mag_out
  );
endinterface

// File: rtl/cordic_atan_seq.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returns atan2(y,x) and the
// gain-scaled (uncompensated) magnitude of a Q2.F vector.
module cordic_atan_seq #(
  parameter int unsigned FRAC_BITS = 30,
  parameter int unsigned NUM_ITER  = 30
) (
  input logic              clk,
  input logic              rst,
  cordic_atan_seq_if.slave bus
);

  localparam int unsigned XW       = FRAC_BITS + 4;
  localparam int unsigned ZW       = FRAC_BITS + 3;
  localparam int unsigned IW       = $clog2(NUM_ITER + 1);
  localparam int unsigned TabLen   = 2 ** IW;
  localparam int unsigned TabScale = 60;

  // atan(1/n) * 2^TabScale by the alternating Taylor series; only used at elaboration.
  function automatic longint atan_inv_scaled(input longint n);
    longint term;
    longint sum;
    int     k;
    term = (longint'(1) <<< TabScale) / n;
    sum  = term;
    k    = 1;
    while (term != 0) begin
      term = term / (n * n);
      if (k % 2 == 1) sum = sum - term / longint'(2 * k + 1);
      else            sum = sum + term / longint'(2 * k + 1);
      k++;
    end
    return sum;
  endfunction

  // atan(2^-i) * 2^TabScale; i=0 uses Machin's formula since the series converges too slowly.
  function automatic longint atan_pow2_scaled(input int i);
    longint sum;
    longint term;
    sum = 0;
    if (i == 0) begin
      sum = 4 * atan_inv_scaled(5) - atan_inv_scaled(239);
    end else begin
      for (int k = 0; i * (2 * k + 1) < 63; k++) begin
        term = (longint'(1) <<< TabScale) >>> (i * (2 * k + 1));
        if (k % 2 == 1) sum = sum - term / longint'(2 * k + 1);
        else            sum = sum + term / longint'(2 * k + 1);
      end
    end
    return sum;
  endfunction

  localparam longint               PiQuarterS = atan_pow2_scaled(0);
  localparam logic signed [ZW-1:0] PiHalf     = ZW'((2 * PiQuarterS) >>> (TabScale - FRAC_BITS));

  // Table padded to a power of two so the iteration counter can never index past the end.
  logic signed [ZW-1:0] atan_tab [TabLen];
  for (genvar g = 0; g < TabLen; g++) begin : g_atan
    localparam longint AtanS = (g < NUM_ITER) ? atan_pow2_scaled(g) : 64'sd0;
    assign atan_tab[g] = ZW'(AtanS >>> (TabScale - FRAC_BITS));
  end

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic        [IW-1:0] iter_q, iter_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic signed [ZW-1:0] theta_q, theta_d;
  logic        [XW-1:0] mag_q, mag_d;

  logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;

  assign x_ext = {{2{bus.x_in[FRAC_BITS+1]}}, bus.x_in};
  assign y_ext = {{2{bus.y_in[FRAC_BITS+1]}}, bus.y_in};
  assign x_sh  = x_q >>> iter_q;
  assign y_sh  = y_q >>> iter_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    theta_d = theta_q;
    mag_d   = mag_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          iter_d  = '0;
          zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
          state_d = StRotate;
          // Fold left-half-plane vectors into the right half so the iterations converge.
          if (!x_ext[XW-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_ext[XW-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = PiHalf;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -PiHalf;
          end
        end
      end
      StRotate: begin
        if (iter_q == IW'(NUM_ITER)) begin
          theta_d = zero_q ? '0 : z_q;
          mag_d   = zero_q ? '0 : $unsigned(x_q);
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          iter_d = iter_q + 1'b1;
          if (!y_q[XW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_tab[iter_q];
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_tab[iter_q];
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      theta_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      theta_q <= theta_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = valid_q;
  assign bus.theta_out = theta_q;
  assign bus.mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_atan_seq.sv
// Scoreboard bench for cordic_atan_seq: accepted vectors push a real-arithmetic atan2/hypot
// expectation; a negedge monitor checks latency, hold-under-backpressure and each result.
module tb_cordic_atan_seq;
  localparam int unsigned F     = 30;
  localparam int unsigned N     = 30;
  localparam longint      One   = 64'sd1 <<< F;
  localparam real         Scale = 1073741824.0;

  typedef logic signed [F+1:0] in_t;
  typedef struct {
    real    theta;
    real    mag;
    real    tol_t;
    real    tol_m;
    longint acc_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  int     rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random
  real    k_gain;
  exp_t   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_atan_seq_if #(.FRAC_BITS(F)) bus ();

  cordic_atan_seq #(.FRAC_BITS(F), .NUM_ITER(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input bit ok, input string act, input string req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input real act, input real req, input real tol);
    real d;
    d = act - req;
    if (d < 0.0) d = -d;
    check(name, d <= tol, $sformatf("%0.1f", act), $sformatf("%0.1f +/- %0.1f", req, tol));
  endtask

  function automatic exp_t model(input longint xi, input longint yi, input longint acc);
    exp_t e;
    real  x, y, r;
    x = real'(xi) / Scale;
    y = real'(yi) / Scale;
    r = $sqrt(x * x + y * y);
    e.acc_cyc = acc;
    if (xi == 0 && yi == 0) begin
      e.theta = 0.0;
      e.mag   = 0.0;
      e.tol_t = 0.0;
      e.tol_m = 0.0;
    end else begin
      e.theta = $atan2(y, x) * Scale;
      e.mag   = k_gain * r * Scale;
      e.tol_t = (r >= 0.0625) ? 256.0 : ((16.0 / r > 256.0) ? 16.0 / r : 256.0);
      e.tol_m = 256.0;
    end
    return e;
  endfunction

  // Output-ready driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic                prev_valid;
    logic                prev_ready;
    logic signed [F+2:0] prev_theta;
    logic        [F+3:0] prev_mag;
    exp_t                e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_theta = '0;
    prev_mag   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready)
          check("hold", bus.out_valid && bus.theta_out == prev_theta && bus.mag_out == prev_mag,
                $sformatf("v=%0b t=%0d m=%0d", bus.out_valid, bus.theta_out, bus.mag_out),
                $sformatf("v=1 t=%0d m=%0d", prev_theta, prev_mag));
        if (bus.out_valid) begin
          check("busy_in_ready", !bus.in_ready, $sformatf("%0b", bus.in_ready), "0");
          if (!prev_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1'b0, "out_valid=1", "no pending");
            else check("latency", cyc - exp_q[0].acc_cyc == N + 1,
                       $sformatf("%0d", cyc - exp_q[0].acc_cyc), $sformatf("%0d", N + 1));
          end
          if (bus.out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_near("theta", real'(bus.theta_out), e.theta, e.tol_t);
            check_near("mag", real'(bus.mag_out), e.mag, e.tol_m);
          end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.x_in, bus.y_in, cyc + 1));
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_theta = bus.theta_out;
        prev_mag   = bus.mag_out;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input longint xv, input longint yv);
    int n;
    n          = 0;
    bus.x_in   = in_t'(xv);
    bus.y_in   = in_t'(yv);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("accept", bus.in_ready, "timeout", "in_ready");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    k_gain = 1.0;
    for (int i = 0; i < N; i++) k_gain = k_gain * $sqrt(1.0 + 1.0 / real'(64'sd1 <<< (2 * i)));
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", !bus.out_valid, $sformatf("%0b", bus.out_valid), "0");
    check("rst_in_ready", bus.in_ready, $sformatf("%0b", bus.in_ready), "1");
    check("rst_theta", bus.theta_out == '0, $sformatf("%0d", bus.theta_out), "0");
    check("rst_mag", bus.mag_out == '0, $sformatf("%0d", bus.mag_out), "0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors: 45 deg, +pi boundary, -pi/2, zero vector.
    send(One, One);   wait_drain(200);
    send(-One, 0);    wait_drain(200);
    send(0, -One);    wait_drain(200);
    send(0, 0);       wait_drain(200);
    send(-One, -One); wait_drain(200);

    // Backpressure: result held 10+ cycles while a second vector waits.
    rdy_mode = 1;
    send(One * 3 / 10, One * 4 / 10);
    bus.x_in     = in_t'(-One / 2);
    bus.y_in     = in_t'(One / 4);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", bus.out_valid, "timeout", "out_valid");
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", !bus.in_ready, $sformatf("%0b", bus.in_ready), "0");
    end
    check("bp_pending", exp_q.size() == 1, $sformatf("%0d", exp_q.size()), "1");
    @(posedge clk);
    #1;
    rdy_mode = 0;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_accept", bus.in_ready, "timeout", "in_ready");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain(200);

    // Reset in place of iteration 5 discards the in-flight vector.
    send(One / 3, One / 5);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", !bus.out_valid, $sformatf("%0b", bus.out_valid), "0");
    check("midrst_in_ready", bus.in_ready, $sformatf("%0b", bus.in_ready), "1");
    check("midrst_theta", bus.theta_out == '0, $sformatf("%0d", bus.theta_out), "0");
    @(posedge clk);
    #1;
    send(One / 2, -One / 2);
    wait_drain(200);

    // Random sweep in [-1.5,1.5) with random output backpressure.
    rdy_mode = 2;
    for (int v = 0; v < 1000; v++) begin
      send(longint'($urandom_range(0, 32'hBFFF_FFFF)) - (3 * One / 2),
           longint'($urandom_range(0, 32'hBFFF_FFFF)) - (3 * One / 2));
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
